// File: rtl/eq_sweep_pkg.sv
// Shared definitions for the equivalence-sweep miter: FSM state encoding.
package eq_sweep_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/eq_sweep_cmp.sv
// Masked output comparator: bitwise diff of the two responses restricted to
// the cared-about bits, plus a single "any bit differs" flag.
module eq_sweep_cmp
  import eq_sweep_pkg::*;
#(
  parameter int N_OUT = 2
) (
  input  logic [N_OUT-1:0] a_i,
  input  logic [N_OUT-1:0] b_i,
  input  logic [N_OUT-1:0] mask_i,
  output logic [N_OUT-1:0] diff_o,
  output logic             any_fail_o
);

  assign diff_o     = (a_i ^ b_i) & mask_i;
  assign any_fail_o = |diff_o;

endmodule

// File: rtl/eq_sweep_checker.sv
// Sequential miter: sweeps a shared stimulus through every input vector,
// waits SETTLE cycles per vector, and records mismatches between A and B.
module eq_sweep_checker
  import eq_sweep_pkg::*;
#(
  parameter int N_IN         = 2,
  parameter int N_OUT        = 2,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] out_mask,
  input  logic [N_OUT-1:0] resp_a,
  input  logic [N_OUT-1:0] resp_b,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             equiv,
  output logic [N_IN-1:0]  fail_vec,
  output logic [N_OUT-1:0] fail_diff,
  output logic [N_IN:0]    fail_cnt
);

  localparam int              CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0]  STIM_LAST = '1;
  localparam logic [N_IN-1:0]  STIM_ONE  = N_IN'(1);
  localparam logic [N_IN:0]    FCNT_MAX  = '1;
  localparam logic [N_IN:0]    FCNT_ONE  = (N_IN+1)'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]    stim_q, stim_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               equiv_q, equiv_d;
  logic [N_IN-1:0]    fail_vec_q, fail_vec_d;
  logic [N_OUT-1:0]   fail_diff_q, fail_diff_d;
  logic [N_IN:0]      fail_cnt_q, fail_cnt_d;

  logic [N_OUT-1:0]   diff;
  logic               any_fail;

  eq_sweep_cmp #(.N_OUT(N_OUT)) u_cmp (
    .a_i        (resp_a),
    .b_i        (resp_b),
    .mask_i     (out_mask),
    .diff_o     (diff),
    .any_fail_o (any_fail)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = done_q;
    equiv_d     = equiv_q;
    fail_vec_d  = fail_vec_q;
    fail_diff_d = fail_diff_q;
    fail_cnt_d  = fail_cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          stim_d      = '0;
          cnt_d       = '0;
          done_d      = 1'b0;
          equiv_d     = 1'b0;
          fail_vec_d  = '0;
          fail_diff_d = '0;
          fail_cnt_d  = '0;
          busy_d      = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_COMPARE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_COMPARE: begin
        if (any_fail) begin
          if (fail_cnt_q != FCNT_MAX) begin
            fail_cnt_d = fail_cnt_q + FCNT_ONE;
          end
          // Only the first mismatch is captured; later ones just count.
          if (fail_cnt_q == '0) begin
            fail_vec_d  = stim_q;
            fail_diff_d = diff;
          end
        end
        if ((stim_q == STIM_LAST) || ((STOP_ON_FAIL != 0) && any_fail)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          equiv_d = (fail_cnt_q == '0) && !any_fail;
        end else begin
          stim_d  = stim_q + STIM_ONE;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      equiv_q     <= 1'b0;
      fail_vec_q  <= '0;
      fail_diff_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      equiv_q     <= equiv_d;
      fail_vec_q  <= fail_vec_d;
      fail_diff_q <= fail_diff_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign equiv     = equiv_q;
  assign fail_vec  = fail_vec_q;
  assign fail_diff = fail_diff_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_eq_sweep_checker.sv
// Directed bench for eq_sweep_checker: four parameterisations driven with
// reference circuit models; expected results flow through a scoreboard queue.
module tb_eq_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] outMask;
  logic       bEquiv;
  logic       start0, start1, start2, start3;

  always #5 clk = ~clk;

  // Reference netlists for the N_IN=2 pairs and the N_IN=4 pair.
  function automatic logic [1:0] respA2(input logic [1:0] s);
    return {~s[1], s[0] | s[1]};
  endfunction

  function automatic logic [1:0] respB2(input logic [1:0] s, input logic eqv);
    return eqv ? {~s[1], (s[1] & ~s[0]) | s[0]} : {~s[0], (s[1] & ~s[0]) | s[0]};
  endfunction

  function automatic logic [1:0] respA4(input logic [3:0] s);
    return {^s, &s[1:0]};
  endfunction

  function automatic logic [1:0] respB4(input logic [3:0] s);
    return respA4(s) ^ ((s == 4'hF) ? 2'b01 : 2'b00);
  endfunction

  logic [1:0] stim0, stim1, stim2, fvec0, fvec1, fvec2, fdiff0, fdiff1, fdiff2, fdiff3;
  logic [2:0] fcnt0, fcnt1, fcnt2;
  logic [3:0] stim3, fvec3;
  logic [4:0] fcnt3;
  logic       busy0, busy1, busy2, busy3, done0, done1, done2, done3;
  logic       equiv0, equiv1, equiv2, equiv3;

  eq_sweep_checker #(.N_IN(2), .N_OUT(2), .SETTLE(1), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .out_mask(outMask),
    .resp_a(respA2(stim0)), .resp_b(respB2(stim0, bEquiv)),
    .stim(stim0), .busy(busy0), .done(done0), .equiv(equiv0),
    .fail_vec(fvec0), .fail_diff(fdiff0), .fail_cnt(fcnt0));

  eq_sweep_checker #(.N_IN(2), .N_OUT(2), .SETTLE(1), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .out_mask(outMask),
    .resp_a(respA2(stim1)), .resp_b(respB2(stim1, 1'b0)),
    .stim(stim1), .busy(busy1), .done(done1), .equiv(equiv1),
    .fail_vec(fvec1), .fail_diff(fdiff1), .fail_cnt(fcnt1));

  eq_sweep_checker #(.N_IN(2), .N_OUT(2), .SETTLE(3), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .out_mask(outMask),
    .resp_a(respA2(stim2)), .resp_b(respB2(stim2, 1'b1)),
    .stim(stim2), .busy(busy2), .done(done2), .equiv(equiv2),
    .fail_vec(fvec2), .fail_diff(fdiff2), .fail_cnt(fcnt2));

  eq_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(1), .STOP_ON_FAIL(0)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .out_mask(outMask),
    .resp_a(respA4(stim3)), .resp_b(respB4(stim3)),
    .stim(stim3), .busy(busy3), .done(done3), .equiv(equiv3),
    .fail_vec(fvec3), .fail_diff(fdiff3), .fail_cnt(fcnt3));

  int          sel;
  logic [31:0] sStim, sCnt, sVec, sDiff;
  logic        sBusy, sDone, sEquiv;

  always_comb begin
    sStim = '0; sCnt = '0; sVec = '0; sDiff = '0;
    sBusy = 1'b0; sDone = 1'b0; sEquiv = 1'b0;
    case (sel)
      0: begin sStim = 32'(stim0); sCnt = 32'(fcnt0); sVec = 32'(fvec0); sDiff = 32'(fdiff0);
               sBusy = busy0; sDone = done0; sEquiv = equiv0; end
      1: begin sStim = 32'(stim1); sCnt = 32'(fcnt1); sVec = 32'(fvec1); sDiff = 32'(fdiff1);
               sBusy = busy1; sDone = done1; sEquiv = equiv1; end
      2: begin sStim = 32'(stim2); sCnt = 32'(fcnt2); sVec = 32'(fvec2); sDiff = 32'(fdiff2);
               sBusy = busy2; sDone = done2; sEquiv = equiv2; end
      default: begin sStim = 32'(stim3); sCnt = 32'(fcnt3); sVec = 32'(fvec3); sDiff = 32'(fdiff3);
               sBusy = busy3; sDone = done3; sEquiv = equiv3; end
    endcase
  end

  typedef struct {
    string tag;
    int    which;
    int    settle;
    int    lastVec;
    int    lat;
    int    restartAt;
    logic  equiv;
    int    cnt;
    int    vec;
    int    diff;
  } exp_t;

  exp_t sb[$];
  int   nAssert = 0;
  int   nFail   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setStart(input int which, input logic v);
    case (which)
      0: start0 = v;
      1: start1 = v;
      2: start2 = v;
      default: start3 = v;
    endcase
  endtask

  // Launch a sweep on one instance and queue what it must report at done.
  task automatic applyStimulus(input exp_t e);
    sb.push_back(e);
    sel = e.which;
    setStart(e.which, 1'b1);
    tick();
    setStart(e.which, 1'b0);
  endtask

  // Follow the sweep cycle by cycle, then pop and check the final verdict.
  task automatic waitDone();
    exp_t e;
    int   c;
    int   expStim;
    bit   seen;
    e    = sb.pop_front();
    c    = 0;
    seen = 1'b0;
    while (c < e.lat + 20 && !seen) begin
      if (c == e.restartAt) setStart(e.which, 1'b1);
      else setStart(e.which, 1'b0);
      tick();
      c++;
      expStim = c / (e.settle + 1);
      if (expStim > e.lastVec) expStim = e.lastVec;
      checkOutput({e.tag, "_stim"}, sStim, 32'(expStim));
      checkOutput({e.tag, "_busy"}, {31'b0, sBusy}, {31'b0, (c < e.lat)});
      if (sDone) seen = 1'b1;
    end
    setStart(e.which, 1'b0);
    checkOutput({e.tag, "_latency"}, 32'(c), 32'(e.lat));
    checkOutput({e.tag, "_equiv"}, {31'b0, sEquiv}, {31'b0, e.equiv});
    checkOutput({e.tag, "_fail_cnt"}, sCnt, 32'(e.cnt));
    checkOutput({e.tag, "_fail_vec"}, sVec, 32'(e.vec));
    checkOutput({e.tag, "_fail_diff"}, sDiff, 32'(e.diff));
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    outMask = 2'b11;
    bEquiv  = 1'b1;
    sel     = 0;
    tick();
    tick();
    checkOutput("rst_stim", sStim, 32'd0);
    checkOutput("rst_busy", {31'b0, sBusy}, 32'd0);
    checkOutput("rst_done", {31'b0, sDone}, 32'd0);
    checkOutput("rst_equiv", {31'b0, sEquiv}, 32'd0);
    checkOutput("rst_fail_cnt", sCnt, 32'd0);
    rst = 1'b0;
    tick();

    applyStimulus('{"t1_equiv", 0, 1, 3, 8, -1, 1'b1, 0, 0, 0});
    waitDone();

    bEquiv = 1'b0;
    applyStimulus('{"t2_noneq", 0, 1, 3, 8, -1, 1'b0, 2, 1, 2});
    waitDone();

    applyStimulus('{"t3_stop", 1, 1, 1, 4, -1, 1'b0, 1, 1, 2});
    waitDone();

    outMask = 2'b01;
    applyStimulus('{"t4_mask01", 0, 1, 3, 8, -1, 1'b1, 0, 0, 0});
    waitDone();
    outMask = 2'b00;
    applyStimulus('{"t4_mask00", 0, 1, 3, 8, -1, 1'b1, 0, 0, 0});
    waitDone();
    outMask = 2'b11;

    sel = 2;
    setStart(2, 1'b1);
    tick();
    setStart(2, 1'b0);
    tick();
    tick();
    checkOutput("t5_busy_pre_rst", {31'b0, sBusy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_busy", {31'b0, sBusy}, 32'd0);
    checkOutput("t5_rst_done", {31'b0, sDone}, 32'd0);
    checkOutput("t5_rst_stim", sStim, 32'd0);
    rst = 1'b0;
    tick();
    applyStimulus('{"t5_settle3", 2, 3, 3, 16, 5, 1'b1, 0, 0, 0});
    waitDone();

    applyStimulus('{"t6_nin4", 3, 1, 15, 32, -1, 1'b0, 1, 15, 1});
    waitDone();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
